// File: rtl/rs_array_pkg.sv
// rs_array_pkg: shared definitions for the reservation-station array.
//   `PRN_BITS : physical register tag width
//   `ROB_BITS : reorder-buffer index width
//   `SD       : optional simulation delay for register updates, empty by default
// Also provides the per-entry control record and a population-count helper.
// Optional feature macro used by this slice: RS_CDB_BYPASS_EN (see rs_entry).

`ifndef RS_ARRAY_DEFS
`define RS_ARRAY_DEFS
`define PRN_BITS 6
`define ROB_BITS 5
`define SD
`endif

package rs_array_pkg;

    localparam int unsigned PrnBits = `PRN_BITS;
    localparam int unsigned RobBits = `ROB_BITS;

    typedef logic [PrnBits-1:0] prn_t;
    typedef logic [RobBits-1:0] rob_t;

    // Control part of one station entry. Operand values and the function code
    // are held beside it because their widths are module parameters.
    typedef struct packed {
        logic in_use;
        logic opa_valid;
        logic opb_valid;
        prn_t prn;
        rob_t rob;
    } rs_ctrl_t;

    function automatic int unsigned count_ones(input logic [31:0] v);
        int unsigned n;
        n = 0;
        for (int i = 0; i < 32; i++) begin
            n += 32'(v[i]);
        end
        return n;
    endfunction

endpackage

// File: rtl/rs_entry.sv
// rs_entry: one reservation-station slot.
// Holds one instruction's operands/tags; loads on dispatch, snoops the CDB to
// wake pending operands, and frees on issue or flush.
// Ports:
//   clk_i, reset_i (sync, active high), flush_i
//   load_i + load_*_i          : dispatch write into this slot
//   free_i                     : issue handshake selected this slot
//   cdb_valid_i/tag_i/data_i   : completion broadcast
//   in_use_o, ready_o          : occupancy and all-operands-valid status
//   opa_o, opb_o, prn_o, rob_o, func_o : stored payload
// Macro RS_CDB_BYPASS_EN: when defined, a broadcast in the dispatch cycle is
// captured into a matching pending operand as it is loaded.

module rs_entry
    import rs_array_pkg::*;
#(
    parameter int unsigned DATA_W = 64,
    parameter int unsigned FUNC_W = 5
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              flush_i,
    input  logic              load_i,
    input  logic              free_i,
    input  logic [DATA_W-1:0] load_opa_i,
    input  logic              load_opa_valid_i,
    input  logic [DATA_W-1:0] load_opb_i,
    input  logic              load_opb_valid_i,
    input  prn_t              load_prn_i,
    input  rob_t              load_rob_i,
    input  logic [FUNC_W-1:0] load_func_i,
    input  logic              cdb_valid_i,
    input  prn_t              cdb_tag_i,
    input  logic [DATA_W-1:0] cdb_data_i,
    output logic              in_use_o,
    output logic              ready_o,
    output logic [DATA_W-1:0] opa_o,
    output logic [DATA_W-1:0] opb_o,
    output prn_t              prn_o,
    output rob_t              rob_o,
    output logic [FUNC_W-1:0] func_o
);

    rs_ctrl_t          ctrl_q, ctrl_d;
    logic [DATA_W-1:0] opa_q, opa_d;
    logic [DATA_W-1:0] opb_q, opb_d;
    logic [FUNC_W-1:0] func_q, func_d;

    logic wake_a, wake_b;

    // Pending operands carry their source tag in the low bits.
    assign wake_a = cdb_valid_i && !ctrl_q.opa_valid && (opa_q[PrnBits-1:0] == cdb_tag_i);
    assign wake_b = cdb_valid_i && !ctrl_q.opb_valid && (opb_q[PrnBits-1:0] == cdb_tag_i);

`ifdef RS_CDB_BYPASS_EN
    logic byp_a, byp_b;
    assign byp_a = cdb_valid_i && !load_opa_valid_i && (load_opa_i[PrnBits-1:0] == cdb_tag_i);
    assign byp_b = cdb_valid_i && !load_opb_valid_i && (load_opb_i[PrnBits-1:0] == cdb_tag_i);
`endif

    always_comb begin
        ctrl_d = ctrl_q;
        opa_d  = opa_q;
        opb_d  = opb_q;
        func_d = func_q;
        if (flush_i) begin
            ctrl_d.in_use = 1'b0;
        end else if (load_i) begin
            ctrl_d.in_use    = 1'b1;
            ctrl_d.opa_valid = load_opa_valid_i;
            ctrl_d.opb_valid = load_opb_valid_i;
            ctrl_d.prn       = load_prn_i;
            ctrl_d.rob       = load_rob_i;
            opa_d            = load_opa_i;
            opb_d            = load_opb_i;
            func_d           = load_func_i;
`ifdef RS_CDB_BYPASS_EN
            if (byp_a) begin
                ctrl_d.opa_valid = 1'b1;
                opa_d            = cdb_data_i;
            end
            if (byp_b) begin
                ctrl_d.opb_valid = 1'b1;
                opb_d            = cdb_data_i;
            end
`endif
        end else if (ctrl_q.in_use) begin
            if (free_i) begin
                ctrl_d.in_use = 1'b0;
            end
            if (wake_a) begin
                ctrl_d.opa_valid = 1'b1;
                opa_d            = cdb_data_i;
            end
            if (wake_b) begin
                ctrl_d.opb_valid = 1'b1;
                opb_d            = cdb_data_i;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            ctrl_q <= '0;
            opa_q  <= '0;
            opb_q  <= '0;
            func_q <= '0;
        end else begin
            ctrl_q <= ctrl_d;
            opa_q  <= opa_d;
            opb_q  <= opb_d;
            func_q <= func_d;
        end
    end

    assign in_use_o = ctrl_q.in_use;
    assign ready_o  = ctrl_q.in_use && ctrl_q.opa_valid && ctrl_q.opb_valid;
    assign opa_o    = opa_q;
    assign opb_o    = opb_q;
    assign prn_o    = ctrl_q.prn;
    assign rob_o    = ctrl_q.rob;
    assign func_o   = func_q;

endmodule

// File: rtl/rs_array.sv
// rs_array: unified reservation station of NUM_ENTRIES rs_entry slots.
// Dispatch fills the lowest free slot; issue presents the lowest ready slot.
// Ports:
//   clock_i, reset_i (sync, active high), flush_i (invalidate all entries)
//   disp_*  : dispatch request from rename, disp_ready_o = a slot is free
//   cdb_*   : completion broadcast used for operand wakeup
//   issue_* : selected ready instruction, handshake with issue_ready_i
//   free_count_o : number of unoccupied slots
// Macro RS_CDB_BYPASS_EN: enables dispatch-cycle CDB capture inside rs_entry.

module rs_array
    import rs_array_pkg::*;
#(
    parameter int unsigned NUM_ENTRIES = 8,
    parameter int unsigned DATA_W      = 64,
    parameter int unsigned FUNC_W      = 5
) (
    input  logic                         clock_i,
    input  logic                         reset_i,
    input  logic                         flush_i,
    input  logic                         disp_valid_i,
    output logic                         disp_ready_o,
    input  logic [DATA_W-1:0]            disp_opa_i,
    input  logic                         disp_opa_valid_i,
    input  logic [DATA_W-1:0]            disp_opb_i,
    input  logic                         disp_opb_valid_i,
    input  logic [PrnBits-1:0]           disp_prn_i,
    input  logic [RobBits-1:0]           disp_rob_i,
    input  logic [FUNC_W-1:0]            disp_func_i,
    input  logic                         cdb_valid_i,
    input  logic [PrnBits-1:0]           cdb_tag_i,
    input  logic [DATA_W-1:0]            cdb_data_i,
    output logic                         issue_valid_o,
    input  logic                         issue_ready_i,
    output logic [DATA_W-1:0]            issue_opa_o,
    output logic [DATA_W-1:0]            issue_opb_o,
    output logic [PrnBits-1:0]           issue_prn_o,
    output logic [RobBits-1:0]           issue_rob_o,
    output logic [FUNC_W-1:0]            issue_func_o,
    output logic [$clog2(NUM_ENTRIES):0] free_count_o
);

    localparam int unsigned IdxW = $clog2(NUM_ENTRIES);
    localparam int unsigned CntW = IdxW + 1;

    logic [NUM_ENTRIES-1:0] in_use;
    logic [NUM_ENTRIES-1:0] ready;
    logic [DATA_W-1:0]      ent_opa  [NUM_ENTRIES];
    logic [DATA_W-1:0]      ent_opb  [NUM_ENTRIES];
    prn_t                   ent_prn  [NUM_ENTRIES];
    rob_t                   ent_rob  [NUM_ENTRIES];
    logic [FUNC_W-1:0]      ent_func [NUM_ENTRIES];

    logic [IdxW-1:0] alloc_idx;
    logic [IdxW-1:0] issue_idx;
    logic            disp_fire;
    logic            issue_fire;
    logic [31:0]     in_use_ext;

    // Occupancy comes straight from entry registers, so disp_ready_o never
    // depends on this cycle's issue handshake.
    always_comb begin
        in_use_ext                = '0;
        in_use_ext[NUM_ENTRIES-1:0] = in_use;
        free_count_o              = CntW'(NUM_ENTRIES - count_ones(in_use_ext));
    end

    assign disp_ready_o = (free_count_o != '0);
    assign disp_fire    = disp_valid_i && disp_ready_o && !flush_i;
    assign issue_valid_o = |ready;
    assign issue_fire   = issue_valid_o && issue_ready_i && !flush_i;

    // Lowest-index free slot. Uses current occupancy, so a slot freed by this
    // cycle's issue is not reused until the next cycle.
    always_comb begin
        alloc_idx = '0;
        for (int i = NUM_ENTRIES - 1; i >= 0; i--) begin
            if (!in_use[i]) begin
                alloc_idx = IdxW'(i);
            end
        end
    end

    // Lowest-index ready slot.
    always_comb begin
        issue_idx = '0;
        for (int i = NUM_ENTRIES - 1; i >= 0; i--) begin
            if (ready[i]) begin
                issue_idx = IdxW'(i);
            end
        end
    end

    for (genvar g = 0; g < NUM_ENTRIES; g++) begin : g_entry
        rs_entry #(
            .DATA_W (DATA_W),
            .FUNC_W (FUNC_W)
        ) u_entry (
            .clk_i            (clock_i),
            .reset_i          (reset_i),
            .flush_i          (flush_i),
            .load_i           (disp_fire && (alloc_idx == IdxW'(g))),
            .free_i           (issue_fire && (issue_idx == IdxW'(g))),
            .load_opa_i       (disp_opa_i),
            .load_opa_valid_i (disp_opa_valid_i),
            .load_opb_i       (disp_opb_i),
            .load_opb_valid_i (disp_opb_valid_i),
            .load_prn_i       (disp_prn_i),
            .load_rob_i       (disp_rob_i),
            .load_func_i      (disp_func_i),
            .cdb_valid_i      (cdb_valid_i),
            .cdb_tag_i        (cdb_tag_i),
            .cdb_data_i       (cdb_data_i),
            .in_use_o         (in_use[g]),
            .ready_o          (ready[g]),
            .opa_o            (ent_opa[g]),
            .opb_o            (ent_opb[g]),
            .prn_o            (ent_prn[g]),
            .rob_o            (ent_rob[g]),
            .func_o           (ent_func[g])
        );
    end

    // Payload is forced to zero whenever nothing is presented.
    always_comb begin
        issue_opa_o  = '0;
        issue_opb_o  = '0;
        issue_prn_o  = '0;
        issue_rob_o  = '0;
        issue_func_o = '0;
        if (issue_valid_o) begin
            issue_opa_o  = ent_opa[issue_idx];
            issue_opb_o  = ent_opb[issue_idx];
            issue_prn_o  = ent_prn[issue_idx];
            issue_rob_o  = ent_rob[issue_idx];
            issue_func_o = ent_func[issue_idx];
        end
    end

endmodule

// File: tb/tb_rs_array.sv
// tb_rs_array: directed self-checking bench for rs_array (8 entries, 64-bit).
// Expected issue records are queued when stimulus is driven and compared when
// an issue handshake happens.

module tb_rs_array;
    import rs_array_pkg::*;

    typedef struct {
        logic [63:0] opa;
        logic [63:0] opb;
        prn_t        prn;
        rob_t        rob;
        logic [4:0]  func;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        flush = 1'b0;
    logic        disp_valid = 1'b0;
    logic        disp_ready;
    logic [63:0] disp_opa = '0;
    logic        disp_opa_valid = 1'b0;
    logic [63:0] disp_opb = '0;
    logic        disp_opb_valid = 1'b0;
    prn_t        disp_prn = '0;
    rob_t        disp_rob = '0;
    logic [4:0]  disp_func = '0;
    logic        cdb_valid = 1'b0;
    prn_t        cdb_tag = '0;
    logic [63:0] cdb_data = '0;
    logic        issue_valid;
    logic        issue_ready = 1'b0;
    logic [63:0] issue_opa;
    logic [63:0] issue_opb;
    prn_t        issue_prn;
    rob_t        issue_rob;
    logic [4:0]  issue_func;
    logic [3:0]  free_count;

    int n_tests = 0;
    int n_fail  = 0;
    exp_t sb[$];

    always #5 clk = ~clk;

    rs_array #(
        .NUM_ENTRIES (8),
        .DATA_W      (64),
        .FUNC_W      (5)
    ) dut (
        .clock_i          (clk),
        .reset_i          (reset),
        .flush_i          (flush),
        .disp_valid_i     (disp_valid),
        .disp_ready_o     (disp_ready),
        .disp_opa_i       (disp_opa),
        .disp_opa_valid_i (disp_opa_valid),
        .disp_opb_i       (disp_opb),
        .disp_opb_valid_i (disp_opb_valid),
        .disp_prn_i       (disp_prn),
        .disp_rob_i       (disp_rob),
        .disp_func_i      (disp_func),
        .cdb_valid_i      (cdb_valid),
        .cdb_tag_i        (cdb_tag),
        .cdb_data_i       (cdb_data),
        .issue_valid_o    (issue_valid),
        .issue_ready_i    (issue_ready),
        .issue_opa_o      (issue_opa),
        .issue_opb_o      (issue_opb),
        .issue_prn_o      (issue_prn),
        .issue_rob_o      (issue_rob),
        .issue_func_o     (issue_func),
        .free_count_o     (free_count)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic exp_t mk(input logic [63:0] a, input logic [63:0] b, input int prn,
                                input int rob, input int func);
        exp_t e;
        e.opa  = a;
        e.opb  = b;
        e.prn  = prn_t'(prn);
        e.rob  = rob_t'(rob);
        e.func = 5'(func);
        return e;
    endfunction

    // Inputs are stable at the falling edge; any handshake there is scored.
    task automatic cycle();
        exp_t e;
        @(negedge clk);
        if (issue_valid && issue_ready) begin
            if (sb.size() == 0) begin
                chk("unexpected_issue_prn", 64'(issue_prn), 64'hFFFF);
            end else begin
                e = sb.pop_front();
                chk("sb_opa", issue_opa, e.opa);
                chk("sb_opb", issue_opb, e.opb);
                chk("sb_prn", 64'(issue_prn), 64'(e.prn));
                chk("sb_rob", 64'(issue_rob), 64'(e.rob));
                chk("sb_func", 64'(issue_func), 64'(e.func));
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic disp(input logic [63:0] a, input logic av, input logic [63:0] b,
                        input logic bv, input int prn, input int rob, input int func);
        disp_opa       = a;
        disp_opa_valid = av;
        disp_opb       = b;
        disp_opb_valid = bv;
        disp_prn       = prn_t'(prn);
        disp_rob       = rob_t'(rob);
        disp_func      = 5'(func);
        disp_valid     = 1'b1;
        cycle();
        disp_valid     = 1'b0;
    endtask

    initial begin
        // Reset state
        cycle();
        cycle();
        reset = 1'b0;
        chk("rst_disp_ready", 64'(disp_ready), 64'd1);
        chk("rst_issue_valid", 64'(issue_valid), 64'd0);
        chk("rst_free_count", 64'(free_count), 64'd8);
        chk("rst_issue_opa", issue_opa, 64'd0);
        chk("rst_issue_prn", 64'(issue_prn), 64'd0);

        // Basic dispatch with both operands ready
        disp(64'd5, 1'b1, 64'd7, 1'b1, 3, 1, 2);
        chk("basic_issue_valid", 64'(issue_valid), 64'd1);
        chk("basic_opa", issue_opa, 64'd5);
        chk("basic_opb", issue_opb, 64'd7);
        chk("basic_prn", 64'(issue_prn), 64'd3);
        chk("basic_free_count", 64'(free_count), 64'd7);
        sb.push_back(mk(64'd5, 64'd7, 3, 1, 2));
        issue_ready = 1'b1;
        cycle();
        issue_ready = 1'b0;
        chk("basic_free_after", 64'(free_count), 64'd8);
        chk("basic_valid_after", 64'(issue_valid), 64'd0);

        // Wakeup: tag 9 pending, broadcast two cycles after dispatch
        disp(64'd9, 1'b0, 64'd7, 1'b1, 4, 2, 1);
        chk("wake_pre0", 64'(issue_valid), 64'd0);
        cycle();
        chk("wake_pre1", 64'(issue_valid), 64'd0);
        cdb_valid = 1'b1;
        cdb_tag   = prn_t'(9);
        cdb_data  = 64'hAB;
        cycle();
        cdb_valid = 1'b0;
        chk("wake_issue_valid", 64'(issue_valid), 64'd1);
        chk("wake_opa", issue_opa, 64'hAB);
        sb.push_back(mk(64'hAB, 64'd7, 4, 2, 1));
        issue_ready = 1'b1;
        cycle();
        issue_ready = 1'b0;

        // Both operands on one tag; a non-matching broadcast must not wake
        disp(64'd10, 1'b0, 64'd10, 1'b0, 5, 3, 3);
        cdb_valid = 1'b1;
        cdb_tag   = prn_t'(11);
        cdb_data  = 64'h77;
        cycle();
        chk("wake_mismatch", 64'(issue_valid), 64'd0);
        cdb_tag  = prn_t'(10);
        cdb_data = 64'h55;
        cycle();
        cdb_valid = 1'b0;
        chk("wake_dual_valid", 64'(issue_valid), 64'd1);
        sb.push_back(mk(64'h55, 64'h55, 5, 3, 3));
        issue_ready = 1'b1;
        cycle();
        issue_ready = 1'b0;

        // Fill every entry, then try a 9th dispatch
        for (int i = 0; i < 8; i++) begin
            disp(64'(i * 16 + 1), 1'b1, 64'(100 + i), 1'b1, i, i, 0);
        end
        chk("full_free_count", 64'(free_count), 64'd0);
        chk("full_disp_ready", 64'(disp_ready), 64'd0);
        disp(64'hDEAD, 1'b1, 64'hBEEF, 1'b1, 31, 31, 31);
        chk("full_ignored", 64'(free_count), 64'd0);
        sb.push_back(mk(64'd1, 64'd100, 0, 0, 0));
        issue_ready = 1'b1;
        cycle();
        issue_ready = 1'b0;
        chk("freed_disp_ready", 64'(disp_ready), 64'd1);
        chk("freed_free_count", 64'(free_count), 64'd1);
        disp(64'hEE, 1'b1, 64'hEF, 1'b1, 20, 20, 4);
        chk("refill_lands_idx0", 64'(issue_prn), 64'd20);
        chk("refill_free_count", 64'(free_count), 64'd0);
        sb.push_back(mk(64'hEE, 64'hEF, 20, 20, 4));
        for (int i = 1; i < 8; i++) begin
            sb.push_back(mk(64'(i * 16 + 1), 64'(100 + i), i, i, 0));
        end
        issue_ready = 1'b1;
        repeat (8) cycle();
        issue_ready = 1'b0;
        chk("drain_free_count", 64'(free_count), 64'd8);
        chk("drain_issue_valid", 64'(issue_valid), 64'd0);

        // Same-cycle dispatch and issue: net free_count 0, slot not reused
        disp(64'h21, 1'b1, 64'h22, 1'b1, 1, 1, 1);
        sb.push_back(mk(64'h21, 64'h22, 1, 1, 1));
        issue_ready = 1'b1;
        disp(64'h31, 1'b1, 64'h32, 1'b1, 2, 2, 2);
        chk("both_free_count", 64'(free_count), 64'd7);
        chk("both_next_prn", 64'(issue_prn), 64'd2);
        sb.push_back(mk(64'h31, 64'h32, 2, 2, 2));
        cycle();
        issue_ready = 1'b0;
        chk("both_free_after", 64'(free_count), 64'd8);

        // Entries 2 and 5 ready, others waiting on tag 30
        for (int i = 0; i < 6; i++) begin
            if (i == 2 || i == 5) begin
                disp(64'(64 + i), 1'b1, 64'(80 + i), 1'b1, 10 + i, i, i);
            end else begin
                disp(64'd30, 1'b0, 64'd0, 1'b1, 10 + i, i, i);
            end
        end
        sb.push_back(mk(64'd66, 64'd82, 12, 2, 2));
        sb.push_back(mk(64'd69, 64'd85, 15, 5, 5));
        chk("prio_first_prn", 64'(issue_prn), 64'd12);
        issue_ready = 1'b1;
        cycle();
        chk("prio_second_prn", 64'(issue_prn), 64'd15);
        cycle();
        issue_ready = 1'b0;
        chk("prio_done_valid", 64'(issue_valid), 64'd0);
        chk("prio_free_count", 64'(free_count), 64'd4);

        // Flush together with dispatch and a wakeup of the waiting entries
        flush          = 1'b1;
        disp_valid     = 1'b1;
        disp_opa       = 64'h1;
        disp_opa_valid = 1'b1;
        disp_opb       = 64'h2;
        disp_opb_valid = 1'b1;
        disp_prn       = prn_t'(7);
        cdb_valid      = 1'b1;
        cdb_tag        = prn_t'(30);
        cdb_data       = 64'h99;
        cycle();
        flush      = 1'b0;
        disp_valid = 1'b0;
        chk("flush_free_count", 64'(free_count), 64'd8);
        chk("flush_issue_valid", 64'(issue_valid), 64'd0);
        cycle();
        cdb_valid = 1'b0;
        chk("flush_no_revive", 64'(issue_valid), 64'd0);

        // Dispatch-cycle broadcast on the pending tag
        cdb_valid = 1'b1;
        cdb_tag   = prn_t'(4);
        cdb_data  = 64'h11;
        disp(64'd4, 1'b0, 64'h66, 1'b1, 6, 6, 6);
        cdb_valid = 1'b0;
`ifdef RS_CDB_BYPASS_EN
        chk("bypass_issue_valid", 64'(issue_valid), 64'd1);
        chk("bypass_opa", issue_opa, 64'h11);
        sb.push_back(mk(64'h11, 64'h66, 6, 6, 6));
        issue_ready = 1'b1;
        cycle();
        issue_ready = 1'b0;
`else
        chk("nobypass_issue_valid", 64'(issue_valid), 64'd0);
        chk("nobypass_free_count", 64'(free_count), 64'd7);
        flush = 1'b1;
        cycle();
        flush = 1'b0;
`endif
        chk("bypass_end_free", 64'(free_count), 64'd8);

        // Reset mid-operation overrides everything in its cycle
        disp(64'h77, 1'b1, 64'h78, 1'b1, 9, 9, 9);
        chk("prereset_valid", 64'(issue_valid), 64'd1);
        reset      = 1'b1;
        flush      = 1'b1;
        disp_valid = 1'b1;
        cdb_valid  = 1'b1;
        cycle();
        reset      = 1'b0;
        flush      = 1'b0;
        disp_valid = 1'b0;
        cdb_valid  = 1'b0;
        chk("midrst_free_count", 64'(free_count), 64'd8);
        chk("midrst_issue_valid", 64'(issue_valid), 64'd0);
        chk("midrst_issue_opa", issue_opa, 64'd0);
        chk("midrst_issue_prn", 64'(issue_prn), 64'd0);

        chk("sb_drained", 64'(sb.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
